// File: rtl/axi_wr_arbiter_2to1.sv
// Two-master, one-slave AXI4 write-channel (AW/W/B) round-robin arbiter.
// One transaction at a time; slave WLAST is regenerated from an internal beat counter.
module axi_wr_arbiter_2to1 #(
  parameter  int ID_W   = 4,
  parameter  int ADDR_W = 32,
  parameter  int LEN_W  = 8,
  parameter  int DATA_W = 32,
  localparam int AW_W   = ID_W + ADDR_W + LEN_W + 2,
  localparam int W_W    = DATA_W + DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2*AW_W-1:0] m_aw_payload,
  input  logic [1:0]        m_awvalid,
  output logic [1:0]        m_awready,
  input  logic [2*W_W-1:0]  m_w_payload,
  input  logic [1:0]        m_wlast,
  input  logic [1:0]        m_wvalid,
  output logic [1:0]        m_wready,
  output logic [2*ID_W-1:0] m_bid,
  output logic [3:0]        m_bresp,
  output logic [1:0]        m_bvalid,
  input  logic [1:0]        m_bready,
  output logic [AW_W-1:0]   s_aw_payload,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [W_W-1:0]    s_w_payload,
  output logic              s_wlast,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [ID_W-1:0]   s_bid,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic              grant,
  output logic              busy,
  output logic              wlast_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t             state, state_nxt;
  logic               prio;
  logic [LEN_W-1:0]   beat_cnt;
  logic [AW_W-1:0]    aw_sel;
  logic [W_W-1:0]     w_sel;
  logic [LEN_W-1:0]   awlen_sel;
  logic               last_beat;
  logic               aw_hs, w_hs, b_hs;

  assign aw_sel    = grant ? m_aw_payload[AW_W +: AW_W] : m_aw_payload[0 +: AW_W];
  assign w_sel     = grant ? m_w_payload[W_W +: W_W]    : m_w_payload[0 +: W_W];
  assign awlen_sel = aw_sel[2 +: LEN_W];
  assign last_beat = (beat_cnt == '0);

  assign aw_hs = (state == ST_AW) && s_awvalid && s_awready;
  assign w_hs  = (state == ST_W)  && s_wvalid  && s_wready;
  assign b_hs  = (state == ST_B)  && s_bvalid  && s_bready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Grant is captured on the IDLE exit edge and held until the next IDLE exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio      <= 1'b0;
      grant     <= 1'b0;
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && |m_awvalid)
        grant <= m_awvalid[prio] ? prio : ~prio;
      if (aw_hs)
        beat_cnt <= awlen_sel;
      else if (w_hs && !last_beat)
        beat_cnt <= beat_cnt - 1'b1;
      wlast_err <= w_hs && (m_wlast[grant] != last_beat);
      if (b_hs)
        prio <= ~grant;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|m_awvalid)         state_nxt = ST_AW;
      ST_AW:   if (aw_hs)              state_nxt = ST_W;
      ST_W:    if (w_hs && last_beat)  state_nxt = ST_B;
      ST_B:    if (b_hs)               state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_awready    = '0;
    m_wready     = '0;
    m_bvalid     = '0;
    s_awvalid    = 1'b0;
    s_wvalid     = 1'b0;
    s_wlast      = 1'b0;
    s_bready     = 1'b0;
    s_aw_payload = aw_sel;
    s_w_payload  = w_sel;
    m_bid        = {2{s_bid}};
    m_bresp      = {2{s_bresp}};
    busy         = (state != ST_IDLE);
    case (state)
      ST_AW: begin
        s_awvalid        = m_awvalid[grant];
        m_awready[grant] = s_awready;
      end
      ST_W: begin
        s_wvalid        = m_wvalid[grant];
        m_wready[grant] = s_wready;
        s_wlast         = last_beat;
      end
      ST_B: begin
        m_bvalid[grant] = s_bvalid;
        s_bready        = m_bready[grant];
      end
      default: ;
    endcase
  end

endmodule
